// File: rtl/blackjack_pkg.sv
// -----------------------------------------------------------------------------
// blackjack_pkg
// Definitions shared by the blackjack timing blocks:
//   - sched_state_e : state encoding of the delay scheduler FSM
//   - REQ_PLAYER / REQ_DEALER : bit index of each requester in i_Req/o_Grant/o_Done
//   - DEFAULT_WIDTH : default width of the external two-second Counter
// -----------------------------------------------------------------------------
package blackjack_pkg;

  localparam int DEFAULT_WIDTH = 12;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_DEALER = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage : blackjack_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter. The priority pointer is held by
// the parent so the arbiter itself has no state.
// Ports:
//   req_i   [1:0] in  : level requests (bit REQ_PLAYER, bit REQ_DEALER)
//   rr_i          in  : priority pointer, 0 favours the player, 1 the dealer
//   grant_o [1:0] out : one-hot winner, all-zero when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
  import blackjack_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; the pointer only breaks a tie.
  assign grant_o[REQ_PLAYER] = req_i[REQ_PLAYER] && (!req_i[REQ_DEALER] || !rr_i);
  assign grant_o[REQ_DEALER] = req_i[REQ_DEALER] && (!req_i[REQ_PLAYER] ||  rr_i);

endmodule : rr_arb2

// File: rtl/delay_scheduler.sv
// -----------------------------------------------------------------------------
// delay_scheduler
// Shares one external two-second Counter between the player and dealer FSMs.
// A granted requester gets a one-cycle Counter clear, then the Counter is
// enabled until its terminal flag arrives, then a one-cycle o_Done pulse.
// A watchdog bounds each timed wait and raises a sticky error on expiry.
// Ports:
//   clk_2K             in  : 2 kHz system clock, rising edge
//   i_Reset            in  : asynchronous active-high reset
//   i_Req        [1:0] in  : level requests (bit0 player, bit1 dealer)
//   o_Grant      [1:0] out : one-hot owner of the Counter, zero when free
//   o_Done       [1:0] out : one-cycle completion pulse to the owner
//   o_RstCounter       out : Counter clear strobe
//   o_ActCounter       out : Counter enable
//   i_TwoSec           in  : Counter terminal flag
//   o_Busy             out : FSM is not IDLE
//   o_Err              out : sticky watchdog error
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module delay_scheduler
  import blackjack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WDOG  = 2**WIDTH + 8
) (
  input  logic       clk_2K,
  input  logic       i_Reset,
  input  logic [1:0] i_Req,
  output logic [1:0] o_Grant,
  output logic [1:0] o_Done,
  output logic       o_RstCounter,
  output logic       o_ActCounter,
  input  logic       i_TwoSec,
  output logic       o_Busy,
  output logic       o_Err
);

  localparam int              WD_W    = WIDTH + 4;
  // Value held during the last permitted COUNT cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

  sched_state_e    state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      done_q,  done_d;
  logic            rstc_q,  rstc_d;
  logic            actc_q,  actc_d;
  logic            busy_q,  busy_d;
  logic            err_q,   err_d;
  logic            rr_q,    rr_d;
  logic [WD_W-1:0] wd_q,    wd_d;

  logic [1:0]      arb_grant;
  logic            owner_req;

  rr_arb2 u_arb (
    .req_i   (i_Req),
    .rr_i    (rr_q),
    .grant_o (arb_grant)
  );

  assign owner_req = |(i_Req & grant_q);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    done_d  = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|i_Req) begin
          grant_d = arb_grant;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = grant_q[REQ_PLAYER];
        end else begin
          state_d = COUNT;
          wd_d    = '0;
        end
      end

      COUNT: begin
        // Abort is tested first so it wins over a coincident terminal flag.
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = grant_q[REQ_PLAYER];
        end else if (i_TwoSec) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (wd_q == WD_LAST) begin
          // Forced completion: DONE without a pulse to the owner.
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
        // Hand priority to the requester that did not just own the Counter.
        rr_d    = grant_q[REQ_PLAYER];
      end

      default: state_d = IDLE;
    endcase

    // Counter controls are decoded from the next state so they line up with
    // the state they belong to once registered.
    rstc_d = (state_d == CLEAR);
    actc_d = (state_d == COUNT);
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge.
  always_ff @(posedge clk_2K or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      rstc_q  <= 1'b0;
      actc_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rstc_q  <= rstc_d;
      actc_q  <= actc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  assign o_Grant      = grant_q;
  assign o_Done       = done_q;
  assign o_RstCounter = rstc_q;
  assign o_ActCounter = actc_q;
  assign o_Busy       = busy_q;
  assign o_Err        = err_q;

endmodule : delay_scheduler

// File: tb/tb_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_delay_scheduler
// Drives delay_scheduler (WIDTH=4, WDOG=24) together with a small Counter
// model whose terminal value is adjustable, and compares its outputs against
// expected values worked out in the bench.
// -----------------------------------------------------------------------------
module tb_delay_scheduler;

  localparam int WDOG = 24;

  logic       clk_2K = 1'b0;
  logic       i_Reset;
  logic [1:0] i_Req;
  logic [1:0] o_Grant;
  logic [1:0] o_Done;
  logic       o_RstCounter;
  logic       o_ActCounter;
  logic       i_TwoSec;
  logic       o_Busy;
  logic       o_Err;

  always #5 clk_2K = ~clk_2K;

  delay_scheduler #(
    .WIDTH (4),
    .WDOG  (WDOG)
  ) dut (
    .clk_2K       (clk_2K),
    .i_Reset      (i_Reset),
    .i_Req        (i_Req),
    .o_Grant      (o_Grant),
    .o_Done       (o_Done),
    .o_RstCounter (o_RstCounter),
    .o_ActCounter (o_ActCounter),
    .i_TwoSec     (i_TwoSec),
    .o_Busy       (o_Busy),
    .o_Err        (o_Err)
  );

  // Counter model: cleared by the strobe, counts while enabled, flags the
  // terminal value. tie0 holds the flag low to starve the scheduler.
  logic [3:0] cnt;
  logic [3:0] term;
  logic       tie0;

  always @(posedge clk_2K or posedge i_Reset) begin
    if (i_Reset)                           cnt <= 4'd0;
    else if (o_RstCounter)                 cnt <= 4'd0;
    else if (o_ActCounter && cnt != 4'hF)  cnt <= cnt + 4'd1;
  end

  assign i_TwoSec = !tie0 && (cnt == term);

  wire [7:0] outs = {o_Grant, o_Done, o_RstCounter, o_ActCounter, o_Busy, o_Err};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_Req = 2'b00;
    tie0  = 1'b0;
    @(negedge clk_2K);
    i_Reset = 1'b1;
    @(negedge clk_2K);
    i_Reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks who owns the Counter, whether the wait is in its
  // clear or counting phase, and whether the completion cycle is showing.
  // ---------------------------------------------------------------------------
  int m_own;        // -1 when free, else requester index
  bit m_counting;   // clear phase done, counter enabled
  bit m_fin;        // in the completion cycle
  bit m_pulse;      // completion cycle carries o_Done
  int m_cnt;        // counting cycles elapsed in this wait
  bit m_rr;         // 1: dealer wins a tie
  bit m_err;

  task automatic model_reset();
    m_own = -1; m_counting = 0; m_fin = 0; m_pulse = 0;
    m_cnt = 0;  m_rr = 0;       m_err = 0;
  endtask

  task automatic model_step(input logic [1:0] req, input logic two);
    if (m_own < 0) begin
      if (req != 2'b00) begin
        m_own      = (req == 2'b11) ? int'(m_rr) : (req[0] ? 0 : 1);
        m_counting = 0;
        m_fin      = 0;
      end
    end else if (m_fin) begin
      m_rr = (m_own == 0); m_own = -1; m_fin = 0; m_pulse = 0;
    end else if (!req[m_own]) begin
      m_rr = (m_own == 0); m_own = -1;
    end else if (!m_counting) begin
      m_counting = 1; m_cnt = 0;
    end else begin
      m_cnt++;
      if (two) begin
        m_fin = 1; m_pulse = 1;
      end else if (m_cnt == WDOG) begin
        m_fin = 1; m_pulse = 0; m_err = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_exp();
    logic [1:0] g;
    logic       live;
    g    = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    live = (m_own >= 0) && !m_fin;
    return {g, (m_fin && m_pulse) ? g : 2'b00, live && !m_counting,
            live && m_counting, m_own >= 0, m_err};
  endfunction

  // ---------------------------------------------------------------------------
  // Single-transaction vectors: requests, counter terminal, optional drop of
  // the owner's request at a given counting cycle, and expected outcome.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] req;
    logic [3:0] term;
    int         drop_at;
    logic [1:0] exp_grant;
    logic [1:0] exp_done;
    int         exp_act;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] first_g, done_acc, seq[2];
    int         act_n, k;
    bit         started, dseen;

    vecs[0] = '{2'b01, 4'd15,  0, 2'b01, 2'b01, 16};
    vecs[1] = '{2'b10, 4'd15,  0, 2'b10, 2'b10, 16};
    vecs[2] = '{2'b11, 4'd4,   0, 2'b01, 2'b01,  5};
    vecs[3] = '{2'b01, 4'd1,   0, 2'b01, 2'b01,  2};
    vecs[4] = '{2'b11, 4'd6,   5, 2'b01, 2'b00,  5};
    vecs[5] = '{2'b10, 4'd9,   1, 2'b10, 2'b00,  1};

    i_Reset = 1'b1; i_Req = 2'b00; tie0 = 1'b0; term = 4'd15;
    #1 check("reset_outputs", outs, 8'h00);
    @(negedge clk_2K);
    i_Reset = 1'b0;

    // Latency: clear strobe in n+1, enable from n+2.
    do_reset();
    term  = 4'd15;
    i_Req = 2'b01;
    @(negedge clk_2K);
    check("lat_clear", {o_Grant, o_RstCounter, o_ActCounter, o_Busy}, 5'b01101);
    @(negedge clk_2K);
    check("lat_count", {o_Grant, o_RstCounter, o_ActCounter, o_Busy}, 5'b01011);

    // Table of single transactions.
    foreach (vecs[i]) begin
      do_reset();
      term     = vecs[i].term;
      i_Req    = vecs[i].req;
      first_g  = 2'b00;
      done_acc = 2'b00;
      act_n    = 0;
      started  = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk_2K);
        if (!started && o_Grant != 2'b00) begin
          started = 1;
          first_g = o_Grant;
        end
        if (o_ActCounter) act_n++;
        if (o_RstCounter && o_ActCounter) check("rst_act_exclusive", 1, 0);
        done_acc |= o_Done;
        if (o_Done != 2'b00) i_Req &= ~o_Done;
        if (vecs[i].drop_at > 0 && o_ActCounter && act_n == vecs[i].drop_at)
          i_Req &= ~vecs[i].exp_grant;
        if (started && o_Grant == 2'b00) break;
      end
      check($sformatf("vec%0d_grant", i), first_g,  vecs[i].exp_grant);
      check($sformatf("vec%0d_done",  i), done_acc, vecs[i].exp_done);
      check($sformatf("vec%0d_act",   i), act_n,    vecs[i].exp_act);
    end

    // Both request right after reset: player first, then dealer.
    do_reset();
    term  = 4'd3;
    i_Req = 2'b11;
    k     = 0;
    seq[0] = 2'b00; seq[1] = 2'b00;
    for (int c = 0; c < 60 && k < 2; c++) begin
      @(negedge clk_2K);
      if (o_Done != 2'b00) begin
        seq[k] = o_Done;
        k++;
        i_Req &= ~o_Done;
      end
    end
    check("rr_first_done",  seq[0], 2'b01);
    check("rr_second_done", seq[1], 2'b10);
    check("rr_done_count",  k, 2);
    @(negedge clk_2K);
    check("rr_grant_free", {o_Grant, o_Busy}, 3'b000);

    // Owner drops at counting cycle 5; pending dealer is served next.
    do_reset();
    term  = 4'd15;
    i_Req = 2'b11;
    act_n = 0;
    dseen = 0;
    for (int c = 0; c < 60 && act_n < 5; c++) begin
      @(negedge clk_2K);
      if (o_ActCounter) act_n++;
      if (o_Done != 2'b00) dseen = 1;
    end
    check("abort_reach_cycle5", act_n, 5);
    i_Req[0] = 1'b0;
    @(negedge clk_2K);
    check("abort_idle", {o_Grant, o_Done, o_ActCounter, o_Busy}, 6'b000000);
    check("abort_no_done", dseen, 0);
    @(negedge clk_2K);
    check("abort_dealer_next", {o_Grant, o_RstCounter}, 3'b101);

    // Starved counter: watchdog forces completion after 24 counting cycles.
    do_reset();
    tie0  = 1'b1;
    i_Req = 2'b01;
    act_n = 0;
    dseen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_2K);
      if (o_Err) break;
      if (o_ActCounter) act_n++;
      if (o_Done != 2'b00) dseen = 1;
    end
    check("wdog_cycles", act_n, WDOG);
    check("wdog_state", {o_Err, o_Busy, o_ActCounter, o_Done}, 5'b11000);
    check("wdog_no_done", dseen, 0);
    i_Req = 2'b00;
    @(negedge clk_2K);
    check("wdog_back_idle", {o_Busy, o_Err}, 2'b01);
    repeat (5) @(negedge clk_2K);
    check("wdog_err_sticky", o_Err, 1);
    do_reset();
    check("wdog_err_cleared", o_Err, 0);

    // Reset pulsed between edges in the middle of a wait.
    do_reset();
    term  = 4'd15;
    i_Req = 2'b01;
    repeat (6) @(negedge clk_2K);
    check("midcount_active", o_ActCounter, 1);
    #2 i_Reset = 1'b1;
    #1 check("async_reset_outputs", outs, 8'h00);
    i_Req = 2'b00;
    @(negedge clk_2K);
    i_Reset = 1'b0;
    dseen = 0;
    repeat (30) begin
      @(negedge clk_2K);
      if (o_Done != 2'b00) dseen = 1;
    end
    check("post_reset_no_done", dseen, 0);

    // Randomised traffic against the reference model.
    do_reset();
    model_reset();
    term = 4'd7;
    for (int c = 0; c < 3000; c++) begin
      check("random_outputs", outs, model_exp());
      if (o_RstCounter) term = 4'($urandom_range(1, 15));
      for (int b = 0; b < 2; b++) begin
        if (!i_Req[b]) begin
          if ($urandom_range(0, 3) == 0) i_Req[b] = 1'b1;
        end else if (o_Done[b]) begin
          i_Req[b] = 1'b0;
        end else if (o_Grant[b] && $urandom_range(0, 39) == 0) begin
          i_Req[b] = 1'b0;
        end else if (!o_Grant[b] && $urandom_range(0, 29) == 0) begin
          i_Req[b] = 1'b0;
        end
      end
      model_step(i_Req, !tie0 && (cnt == term));
      @(negedge clk_2K);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_delay_scheduler

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the bit width of the shared Counter's count.
REQ-002 SHALL have parameter WDOG, default 2**WIDTH+8, the cycle limit for one timed wait before an error is raised.
REQ-003 SHALL have port clk_2K  input  1  system clock (2 kHz); one clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port i_Req  input  2  level requests for a two-second wait; bit0 is player FSM, bit1 is dealer FSM.
REQ-006 SHALL have port o_Grant  output  2  one-hot owner of the shared Counter; all-zero when free.
REQ-007 SHALL have port o_Done  output  2  one-cycle pulse to the owner when its wait completes.
REQ-008 SHALL have port o_RstCounter  output  1  clear strobe to the Counter's i_RstCounter.
REQ-009 SHALL have port o_ActCounter  output  1  enable to the Counter's i_ActCounter.
REQ-010 SHALL have port i_TwoSec  input  1  terminal flag from the Counter's o_TwoSec.
REQ-011 SHALL have port o_Busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_Err  output  1  sticky watchdog error flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, CLEAR, COUNT and DONE; all outputs are registered.
REQ-014 IDLE: when i_Req is nonzero, SHALL select a winner by round-robin, set o_Grant to the winner's bit and go to CLEAR. With i_Req=0 it stays in IDLE.
REQ-015 Round-robin: pointer rr=0 after reset gives bit0 priority. After each DONE or abort, rr points to the other requester. A lone requester always wins.
REQ-016 CLEAR: SHALL drive o_RstCounter=1 and o_ActCounter=0 for exactly one cycle, then go to COUNT.
REQ-017 COUNT: SHALL drive o_ActCounter=1 and o_RstCounter=0, and go to DONE on the first cycle i_TwoSec is sampled 1.
REQ-018 DONE: SHALL drive o_Done[owner]=1 for exactly one cycle with o_ActCounter=0, then clear o_Grant, update rr and go to IDLE.
REQ-019 Latency: a request sampled in IDLE at edge n SHALL give o_RstCounter high in cycle n+1, o_ActCounter high from n+2, and o_Done one cycle after i_TwoSec is sampled.
REQ-020 A request held high in the cycle after o_Done SHALL count as a new request; requesters drop i_Req in response to o_Done.
REQ-021 Abort: if the owner's i_Req falls during CLEAR or COUNT, SHALL go to IDLE next cycle with no o_Done, o_ActCounter=0, o_Grant=0 and rr updated.
REQ-022 A non-owner request SHALL be held pending and never preempt the owner.
REQ-023 Simultaneous abort and i_TwoSec in COUNT: abort wins, so no o_Done.
REQ-024 Watchdog: a WIDTH+4-bit cycle counter SHALL run only in COUNT and clear on entry to COUNT.
REQ-025 If the watchdog reaches WDOG without i_TwoSec, SHALL set o_Err=1 and force DONE with no o_Done pulse.
REQ-026 o_Err SHALL clear only on reset.
REQ-027 o_RstCounter and o_ActCounter SHALL never be high in the same cycle.

Reset
REQ-028 On i_Reset=1, SHALL asynchronously force state=IDLE, o_Grant=0, o_Done=0, o_RstCounter=0, o_ActCounter=0, o_Busy=0, o_Err=0, rr=0 and watchdog=0.
REQ-029 Reset asserted mid-COUNT SHALL abandon the wait with no o_Done.
REQ-030 After reset release, SHALL resume normal operation from the first rising edge.

Structure
REQ-031 SHALL place the state encoding, requester indices (REQ_PLAYER=0, REQ_DEALER=1) and default WIDTH in the shared package blackjack_pkg.
REQ-032 SHALL implement round-robin selection as the one sub-module rr_arb2, combinational with the rr register kept in the parent.
REQ-033 The Counter is external and not instantiated inside this block.

Verification
REQ-034 Bench SHALL use the Counter (or a model) with WIDTH=4 and WDOG=24.
REQ-035 i_Req=01 held -> o_RstCounter pulse at n+1; o_ActCounter high from n+2 until TwoSec; o_Done=01 for one cycle; o_Grant returns to 00.
REQ-036 i_Req=11 in the same cycle right after reset -> player served first, then dealer; o_Done pulses 01 then 10.
REQ-037 Owner drops i_Req at COUNT cycle 5 -> IDLE next cycle; no o_Done; the pending dealer request is granted next.
REQ-038 i_TwoSec tied 0 -> o_Err=1 after 24 COUNT cycles; FSM returns to IDLE; o_Err stays 1 until i_Reset.
REQ-039 i_Reset pulsed mid-COUNT, between clock edges -> all outputs are 0 immediately; no o_Done after release.
